// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: decodes 'W'/'R' command frames from the UART
// receiver, performs one 32-bit bus read or write, and replies over the UART
// transmitter (one ack byte for a write, four data bytes MSB first for a read).
//
// Handshakes: rx_valid is a one-cycle strobe with no back-pressure, so bytes
// that arrive while the block is busy with a bus cycle or a reply are dropped.
// tx_start is a one-cycle strobe issued only while tx_busy is low; tx_data is
// held until the transmitter drops tx_busy again.
module uart_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  CMD_WR         = 8'h57,
   parameter logic [7:0]  CMD_RD         = 8'h52,
   parameter logic [7:0]  RSP_ACK        = 8'h4B,
   parameter logic [7:0]  RSP_ERR        = 8'h45
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic        rd,
   output logic        wr,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        busy,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_DATA   = 3'd2,
      S_BUS    = 3'd3,
      S_RESP   = 3'd4,
      S_TXWAIT = 3'd5
   } state_t;

   localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state_q,    state_d;
   logic        is_wr_q,    is_wr_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] timer_q,    timer_d;
   logic [31:0] addr_q,     addr_d;
   logic [31:0] wdata_q,    wdata_d;
   logic [31:0] rsp_q,      rsp_d;
   logic [2:0]  rsp_left_q, rsp_left_d;
   logic [7:0]  tx_data_q,  tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic        guard_q,    guard_d;

   // State and datapath registers; asynchronous reset aborts any frame or reply.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         is_wr_q    <= 1'b0;
         byte_cnt_q <= 2'd0;
         timer_q    <= 32'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         rsp_q      <= 32'd0;
         rsp_left_q <= 3'd0;
         tx_data_q  <= 8'd0;
         tx_start_q <= 1'b0;
         guard_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         byte_cnt_q <= byte_cnt_d;
         timer_q    <= timer_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rsp_q      <= rsp_d;
         rsp_left_q <= rsp_left_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         guard_q    <= guard_d;
      end
   end

   // Next-state logic: frame decode, inter-byte timeout, bus cycle, reply sequencing.
   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      byte_cnt_d = byte_cnt_q;
      timer_d    = timer_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rsp_d      = rsp_q;
      rsp_left_d = rsp_left_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      guard_d    = guard_q;
      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                  is_wr_d    = (rx_data == CMD_WR);
                  byte_cnt_d = 2'd0;
                  timer_d    = 32'd0;
                  state_d    = S_ADDR;
               end else begin
                  rsp_d      = {RSP_ERR, 24'h0};
                  rsp_left_d = 3'd1;
                  state_d    = S_RESP;
               end
            end
         end
         S_ADDR, S_DATA: begin
            if (rx_valid) begin
               if (state_q == S_ADDR) addr_d  = {addr_q[23:0], rx_data};
               else                   wdata_d = {wdata_q[23:0], rx_data};
               timer_d    = 32'd0;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (state_q == S_ADDR && is_wr_q) state_d = S_DATA;
                  else                              state_d = S_BUS;
               end
            end else if (timer_q == TIMER_LAST) begin
               timer_d = 32'd0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         S_BUS: begin
            if (is_wr_q) begin
               rsp_d      = {RSP_ACK, 24'h0};
               rsp_left_d = 3'd1;
            end else begin
               rsp_d      = rdata;
               rsp_left_d = 3'd4;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            if (!tx_busy) begin
               tx_data_d  = rsp_q[31:24];
               rsp_d      = {rsp_q[23:0], 8'h00};
               rsp_left_d = rsp_left_q - 3'd1;
               tx_start_d = 1'b1;
               guard_d    = 1'b1;
               state_d    = S_TXWAIT;
            end
         end
         S_TXWAIT: begin
            // The guard cycle gives the transmitter time to raise tx_busy.
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (!tx_busy) begin
               state_d = (rsp_left_q != 3'd0) ? S_RESP : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rd          = (state_q == S_BUS) && !is_wr_q;
   assign wr          = (state_q == S_BUS) && is_wr_q;
   assign addr        = addr_q;
   assign wdata       = wdata_q;
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_bus_master.sv
module tb_uart_bus_master;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        busy;
  logic [2:0]  dbg_state;

  logic [31:0] rd_value = 32'h0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_wdata = 32'h0;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_tx = 8'h00;
  logic [3:0]  busy_cnt;
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          tx_cnt = 0;

  uart_bus_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // bus responder: read data only meaningful while rd is high
  assign rdata = rd ? rd_value : 32'hDEAD_BEEF;

  // UART transmitter model: busy for a random 3..8 cycles after each tx_start
  always @(posedge clk or negedge reset) begin
    if (!reset) busy_cnt <= 4'd0;
    else if (tx_start) busy_cnt <= 4'($urandom_range(3, 8));
    else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
  end
  assign tx_busy = (busy_cnt != 4'd0);

  // scoreboard: tx bytes popped from exp_q as the DUT starts them
  always @(negedge clk) begin
    if (reset && tx_start) begin
      checks++;
      tx_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got tx_data=%02h, expected no transmission", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_data, e);
        end
      end
      if (tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL tx_start_while_busy: tx_busy=%b, expected 0", tx_busy);
      end
      last_tx = tx_data;
    end else if (reset && tx_busy && tx_data !== last_tx) begin
      checks++;
      errors++;
      $display("FAIL tx_data_stable: got %02h, expected %02h", tx_data, last_tx);
    end
  end

  // bus monitor
  always @(negedge clk) begin
    if (reset) begin
      if (rd && wr) begin
        checks++;
        errors++;
        $display("FAIL rd_wr_overlap: rd=%b wr=%b, expected not both", rd, wr);
      end
      if (wr) begin
        checks++;
        wr_cnt++;
        if (addr !== exp_addr || wdata !== exp_wdata) begin
          errors++;
          $display("FAIL wr_cycle: got addr=%08h wdata=%08h, expected addr=%08h wdata=%08h",
                   addr, wdata, exp_addr, exp_wdata);
        end
      end
      if (rd) begin
        checks++;
        rd_cnt++;
        if (addr !== exp_addr) begin
          errors++;
          $display("FAIL rd_cycle: got addr=%08h, expected %08h", addr, exp_addr);
        end
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    exp_addr  = a;
    exp_wdata = d;
    exp_q.push_back(RSP_ACK);
    send_byte(CMD_WR);
    send_word(a);
    send_word(d);
  endtask

  task automatic send_read(input logic [31:0] a, input logic [31:0] d);
    exp_addr = a;
    rd_value = d;
    for (int i = 3; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
    send_byte(CMD_RD);
    send_word(a);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && !tx_busy && exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b pending=%0d after %0d cycles, expected idle with 0 pending",
               name, busy, exp_q.size(), budget);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (rd !== 1'b0 || wr !== 1'b0 || tx_start !== 1'b0 || busy !== 1'b0 ||
        addr !== 32'h0 || wdata !== 32'h0 || tx_data !== 8'h00 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL %s: got rd=%b wr=%b tx_start=%b busy=%b addr=%08h wdata=%08h tx_data=%02h state=%0d, expected all 0",
               name, rd, wr, tx_start, busy, addr, wdata, tx_data, dbg_state);
    end
  endtask

  task automatic check_counts(input string name, input int wr_exp, input int rd_exp);
    checks++;
    if (wr_cnt !== wr_exp || rd_cnt !== rd_exp) begin
      errors++;
      $display("FAIL %s_strobes: got wr=%0d rd=%0d, expected wr=%0d rd=%0d",
               name, wr_cnt, rd_cnt, wr_exp, rd_exp);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_write();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    send_write(32'h4000_000C, 32'h0000_00A5);
    wait_idle("write", 200);
    check_counts("write", w0 + 1, r0);
    checks++;
    if (addr !== 32'h4000_000C || wdata !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL write_hold: got addr=%08h wdata=%08h, expected 4000000c 000000a5", addr, wdata);
    end
  endtask

  task automatic test_read();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    send_read(32'h4000_0010, 32'h0000_005A);
    wait_idle("read", 300);
    check_counts("read", w0, r0 + 1);
  endtask

  task automatic test_bad_cmd();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    exp_q.push_back(RSP_ERR);
    send_byte(8'h33);
    wait_idle("bad_cmd", 100);
    check_counts("bad_cmd", w0, r0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    send_byte(CMD_WR);
    send_byte(8'h40);
    send_byte(8'h00);
    repeat (50) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: busy=%b after 50 idle cycles, expected 1", busy);
    end
    repeat (55) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: busy=%b after 105 idle cycles, expected 0", busy);
    end
    check_counts("timeout", w0, r0);
    send_write(32'h1234_5678, 32'hCAFE_F00D);
    wait_idle("timeout_next", 200);
    check_counts("timeout_next", w0 + 1, r0);
  endtask

  task automatic test_reset_mid();
    int t0, w0, r0;
    bit hit;
    send_read(32'h4000_0020, 32'hA1B2_C3D4);
    t0 = tx_cnt;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (tx_cnt == t0 + 2) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_wait: got %0d tx bytes, expected 2", tx_cnt - t0);
    end
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("reset_mid_outputs");
    @(posedge clk); #1;
    reset = 1'b1;
    t0 = tx_cnt; w0 = wr_cnt; r0 = rd_cnt;
    repeat (30) @(negedge clk);
    check_reset_outputs("reset_mid_quiet");
    checks++;
    if (tx_cnt !== t0) begin
      errors++;
      $display("FAIL reset_mid_tx: got %0d tx_start after reset, expected 0", tx_cnt - t0);
    end
    check_counts("reset_mid", w0, r0);
  endtask

  task automatic test_drop_txwait();
    int t0, w0, r0;
    bit hit;
    w0 = wr_cnt; r0 = rd_cnt;
    send_read(32'h4000_0030, 32'h1122_3344);
    t0 = tx_cnt;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (tx_cnt == t0 + 1) hit = 1'b1;
    end
    checks++;
    if (!hit || dbg_state !== 3'd5) begin
      errors++;
      $display("FAIL drop_reach_txwait: hit=%b state=%0d, expected 1 and 5", hit, dbg_state);
    end
    send_byte(CMD_RD);
    send_byte(8'h33);
    send_byte(CMD_WR);
    wait_idle("drop", 300);
    check_counts("drop", w0, r0 + 1);
    send_read(32'h4000_0044, 32'h8765_4321);
    wait_idle("drop_next", 300);
    check_counts("drop_next", w0, r0 + 2);
  endtask

  task automatic test_back_to_back();
    int w0, r0, nw, nr;
    w0 = wr_cnt; r0 = rd_cnt; nw = 0; nr = 0;
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        send_write($urandom, $urandom);
        nw++;
      end else begin
        send_read($urandom, $urandom);
        nr++;
      end
      wait_idle("b2b", 300);
    end
    check_counts("b2b", w0 + nw, r0 + nr);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_timeout();
    test_reset_mid();
    test_drop_txwait();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
